// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared datapath types, including instruction cache frame and state types
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_FRAMES = 16;

  // Tag field is sized for the smallest legal cache (2 frames); larger caches zero-extend.
  localparam int ICACHE_TAG_W = 29;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache; optional counters via ICACHE_STATS_EN
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int NFRAMES = ICACHE_FRAMES
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output word_t       imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  word_t       iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(NFRAMES);
  localparam int TAG_W = 30 - IDX_W;

  icache_frame_t frames [NFRAMES];
  icache_state_t state;
  word_t         miss_addr;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  icache_frame_t    sel;

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign miss_idx = miss_addr[IDX_W+1:2];
  assign miss_tag = miss_addr[31:IDX_W+2];
  assign sel      = frames[req_idx];

  assign ihit     = (state == IDLE) && imemREN && sel.valid
                    && (sel.tag == ICACHE_TAG_W'(req_tag));
  assign imemload = ihit ? sel.data : '0;

  // Memory-side request depends only on registered state, never on the fetch address.
  assign iREN  = (state == FETCH);
  assign iaddr = iREN ? miss_addr : '0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      for (int i = 0; i < NFRAMES; i++) begin
        frames[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !ihit) begin
            miss_addr <= imemaddr & 32'hFFFF_FFFC;
            state     <= FETCH;
          end
        end
        FETCH: begin
          // The fill uses the latched address even if the request was squashed meanwhile.
          if (!iwait) begin
            frames[miss_idx] <= '{valid: 1'b1, tag: ICACHE_TAG_W'(miss_tag), data: iload};
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (ihit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if ((state == IDLE) && imemREN && !ihit) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt;
  assign miss_count = miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - directed scoreboard bench for icache_direct
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  bit          mvalid [16];
  logic [25:0] mtag   [16];

  icache_direct #(.NFRAMES(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2008_0005;
    return (a ^ 32'hC0DE_0000) + 32'h0000_1001;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  // Issue a fetch, act as memory for any resulting miss, and score the returned word.
  task automatic request(input logic [31:0] a, input int nwait);
    logic [31:0] wa;
    int          idx;
    bit          exp_miss;
    int          fetch_cycles;
    int          waited;
    int          cyc;
    bit          got;
    wa           = a & 32'hFFFF_FFFC;
    idx          = int'(wa[5:2]);
    exp_miss     = !(mvalid[idx] && (mtag[idx] == wa[31:6]));
    fetch_cycles = 0;
    waited       = 0;
    cyc          = 0;
    got          = 1'b0;
    exp_q.push_back(mem_data(wa));
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    #1;
    while (!got && cyc < 50) begin
      if (ihit === 1'b1) begin
        got = 1'b1;
      end else begin
        if (iREN === 1'b1) begin
          check("miss_iaddr", iaddr, wa);
          fetch_cycles++;
          iwait = (waited < nwait);
          iload = mem_data(wa);
          waited++;
        end
        step();
        cyc++;
      end
    end
    if (!got) begin
      check("hit_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      check("fetch_cycles", fetch_cycles, exp_miss ? nwait + 1 : 0);
      check("imemload", imemload, exp_q.pop_front());
      check("iren_on_hit", {31'd0, iREN}, 32'd0);
    end
    if (exp_miss) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = wa[31:6];
    end
    iwait = 1'b1;
  endtask

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
    clear_model();

    #3;
    check("rst_ihit", {31'd0, ihit}, 32'd0);
    check("rst_imemload", imemload, 32'd0);
    check("rst_iren", {31'd0, iREN}, 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    step();

    // Cold miss with three busy cycles, then warm hit.
    request(32'h0000_0040, 3);
    request(32'h0000_0040, 0);

    // Conflict eviction on index 0, plus a separate index and ignored byte offset.
    request(32'h0000_0080, 1);
    request(32'h0000_0040, 0);
    request(32'h0000_0044, 2);
    request(32'h0000_0044, 0);
    request(32'h0000_0041, 0);

    // Squash: address changes while the 0x100 fill is outstanding.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0100;
    iwait    = 1'b1;
    #1;
    check("squash_c0_hit", {31'd0, ihit}, 32'd0);
    step();
    check("squash_iren", {31'd0, iREN}, 32'd1);
    check("squash_iaddr", iaddr, 32'h0000_0100);
    imemaddr = 32'h0000_0200;
    imemREN  = 1'b0;
    step();
    check("squash_iaddr_hold", iaddr, 32'h0000_0100);
    check("squash_fetch_hit", {31'd0, ihit}, 32'd0);
    check("squash_fetch_load", imemload, 32'd0);
    iwait = 1'b0;
    iload = mem_data(32'h0000_0100);
    step();
    check("squash_return_iren", {31'd0, iREN}, 32'd0);
    check("squash_return_iaddr", iaddr, 32'd0);
    iwait     = 1'b1;
    mvalid[0] = 1'b1;
    mtag[0]   = 26'h4;
    request(32'h0000_0100, 0);
    request(32'h0000_0200, 1);

    // Reset in the middle of a fill.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0300;
    iwait    = 1'b1;
    step();
    check("rstfetch_iren_pre", {31'd0, iREN}, 32'd1);
    #2;
    nRST    = 1'b0;
    imemREN = 1'b0;
    #1;
    check("rstfetch_iren", {31'd0, iREN}, 32'd0);
    check("rstfetch_iaddr", iaddr, 32'd0);
    clear_model();
    @(negedge CLK);
    nRST = 1'b1;
    step();
    request(32'h0000_0300, 0);
    check("rstfetch_refetched", {31'd0, mvalid[0]}, 32'd1);

    // Counters: one cold miss then five hit cycles from a fresh reset.
    imemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b0;
    clear_model();
    #1;
    check("stats_rst_hits", hit_count, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    step();
    request(32'h0000_0500, 0);
    repeat (4) begin
      step();
      check("stats_hold_hit", {31'd0, ihit}, 32'd1);
    end
    step();
    imemREN = 1'b0;
    #1;
`ifdef ICACHE_STATS_EN
    check("stats_miss_count", miss_count, 32'd1);
    check("stats_hit_count", hit_count, 32'd5);
`else
    check("stats_miss_count", miss_count, 32'd0);
    check("stats_hit_count", hit_count, 32'd0);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port and the memory controller's instruction port. It serves the fetch stage's `imemaddr`/`imemREN` requests and returns `ihit`/`imemload`. On a miss it issues a single-word read (`iREN`/`iaddr`), waits out `iwait`, fills the frame and then hits. With `imemREN` held, the datapath stalls until `ihit`; it needs no other change.

## Interface
- `NFRAMES`, default 16: number of frames; power of two, at least 2.
- `CLK` input 1: rising-edge clock.
- `nRST` input 1: asynchronous active-low reset.
- `imemREN` input 1: datapath fetch request.
- `imemaddr` input 32: fetch byte address; bits [1:0] are ignored.
- `ihit` output 1: requested word is valid on `imemload` this cycle.
- `imemload` output 32: instruction word; 0 when `ihit`=0.
- `iREN` output 1: read request to the memory controller.
- `iaddr` output 32: word-aligned miss address to the memory controller.
- `iwait` input 1: memory controller busy; the read completes in the cycle `iwait`=0 while `iREN`=1.
- `iload` input 32: read data, valid when `iREN`=1 and `iwait`=0.
- `hit_count` output 32: hit counter; see Configuration.
- `miss_count` output 32: miss counter; see Configuration.

## Operation
- Address split:
  - index = `imemaddr`[IDX_W+1:2], with IDX_W = log2(NFRAMES).
  - tag = `imemaddr`[31:IDX_W+2].
- Each frame holds {valid, tag, data word}.
- Two states:
  - **IDLE**:
    - `ihit` = `imemREN` & frame.valid & (frame.tag == tag). `imemload` = frame.data when `ihit`, else 0.
    - On `imemREN` & !hit: latch the word-aligned `imemaddr` into `miss_addr` and go to FETCH. `ihit`=0 this cycle.
  - **FETCH**:
    - `iREN`=1, `iaddr`=`miss_addr`; `ihit`=0.
    - When `iwait`=0: write frame[index(`miss_addr`)] = {1, tag(`miss_addr`), `iload`} and return to IDLE.
- Outside FETCH, `iREN`=0 and `iaddr`=0.
- A fill overwrites whatever the frame held; there is no victim handling because the cache is read-only.
- Once FETCH starts it completes with the latched `miss_addr`, even if `imemREN` drops or `imemaddr` changes (e.g. a branch squash). The filled line stays valid and costs nothing.
- A request to a different address arriving in the return cycle is evaluated fresh in IDLE.
- There is no write or invalidate path; self-modifying code is unsupported.

## Timing
- Reset: state=IDLE, all valid bits=0, `miss_addr`=0, counters=0. Outputs: `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
- Hit latency is 0: `ihit` is combinational in the same cycle as the request.
- Miss timeline:
  - Cycle 0: miss detected.
  - Cycles 1..N: FETCH with `iREN`=1; `iwait`=0 in cycle N.
  - Cycle N+1: IDLE, hit if the request is unchanged.
  - Minimum miss cost is 2 cycles, with `iwait`=0 in the first FETCH cycle.
- `iREN` is driven from registered state only, never from `imemaddr` directly.
- Reset asserted mid-FETCH: state→IDLE and `iREN`→0 immediately. The in-flight fill is dropped and its frame is not written.
- The frame write and the IDLE transition occur on the same edge; the tag/data read in the next cycle sees the new contents.

## Configuration
- Macro: `ICACHE_STATS_EN`.
- Defined:
  - `hit_count` increments by 1 on every cycle with `ihit`=1.
  - `miss_count` increments by 1 on every IDLE→FETCH transition.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both counter registers are omitted and `hit_count`=`miss_count`=0 constantly. Cache behaviour is otherwise identical.

## Structure
- `cpu_types_pkg` gets:
  - `ICACHE_FRAMES` (default for `NFRAMES`).
  - `icache_frame_t` packed struct {valid, tag, word_t data}.
  - `icache_state_t` enum {IDLE, FETCH}.
- Tag width is derived locally from `NFRAMES`.
- Existing `word_t` is reused for the data word.
- No sub-module: the frame array, comparator and two-state FSM stay in `icache_direct`.

## Test plan
- **Cold miss:** after reset, `imemREN`=1, `imemaddr`=0x0000_0040, memory `iwait`=1 for 3 cycles, `iload`=0x2008_0005.
  - Cycle 0: `ihit`=0.
  - `iREN`=1 and `iaddr`=0x40 for 4 cycles.
  - Then `ihit`=1 and `imemload`=0x2008_0005.
- **Warm hit:** re-request 0x40 → `ihit`=1 in the same cycle with no `iREN` activity.
- **Conflict eviction:** fill 0x40, then request 0x80 (same index, different tag).
  - The 0x80 request misses and its frame is refilled.
  - Re-requesting 0x40 misses again.
- **Squash mid-fetch:** miss on 0x100; while in FETCH, switch `imemaddr` to 0x200.
  - `iaddr` stays 0x100 until `iwait`=0.
  - 0x200 then misses; a later request to 0x100 hits.
- **Reset mid-fetch:** assert `nRST`=0 during FETCH.
  - `iREN` drops asynchronously.
  - After release, a request to the same address misses.
- **Stats (`ICACHE_STATS_EN` defined):** 1 cold miss followed by 5 hit cycles → `miss_count`=1, `hit_count`=5.
  - Undefined build, same stimulus: both counters read 0.
